// File: rtl/window_sampler.sv
// Windowed, decimated input sampler with a free-running frame counter,
// per-sample valid strobe, frame-wrap pulse and per-frame sample tally.
module window_sampler #(
  parameter int DATA_W    = 4,
  parameter int CNT_W     = 4,
  parameter int PERIOD    = 16,
  parameter int BLANK_END = 4,
  parameter int WIN_END   = 8,
  parameter int DECIM     = 2,
  parameter int PHASE     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              hold_mode,
  input  logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] y,
  output logic              y_valid,
  output logic [CNT_W-1:0]  count,
  output logic              frame_done,
  output logic [CNT_W-1:0]  frame_samples
);

  generate
    if (!(BLANK_END <= WIN_END && WIN_END < PERIOD &&
          DECIM >= 1 && PHASE < DECIM &&
          PERIOD <= 2**CNT_W)) begin : g_param_err
      $error("window_sampler: inconsistent parameters");
    end
  endgenerate

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  tally_q, tally_d;
  logic [CNT_W-1:0]  fs_q, fs_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic              vld_q, vld_d;
  logic              fd_q, fd_d;

  int   c;
  logic in_blank, in_win, on_phase;
  logic take, wrap;
  logic [CNT_W-1:0] take_w;

  assign c        = int'(count_q);
  assign in_blank = c < BLANK_END;
  assign in_win   = (c >= BLANK_END) && (c <= WIN_END);
  assign on_phase = (c % DECIM) == PHASE;
  assign take     = enable && in_win && on_phase;
  assign wrap     = count_q == LAST;
  assign take_w   = {{(CNT_W-1){1'b0}}, take};

  // Region decode on the pre-edge count selects the next y/valid/tally.
  always_comb begin
    count_d = wrap ? '0 : count_q + 1'b1;
    fd_d    = wrap;
    vld_d   = take;
    y_d     = y_q;
    if (take)
      y_d = x;
    else if (enable && in_blank && !hold_mode)
      y_d = '0;
    // A sample on the wrap edge belongs to the closing frame.
    fs_d    = wrap ? tally_q + take_w : fs_q;
    tally_d = wrap ? '0 : tally_q + take_w;
  end

  // State registers; reset aborts the current frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      tally_q <= '0;
      fs_q    <= '0;
      y_q     <= '0;
      vld_q   <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tally_q <= tally_d;
      fs_q    <= fs_d;
      y_q     <= y_d;
      vld_q   <= vld_d;
      fd_q    <= fd_d;
    end
  end

  assign y             = y_q;
  assign y_valid       = vld_q;
  assign count         = count_q;
  assign frame_done    = fd_q;
  assign frame_samples = fs_q;

endmodule
